// File: rtl/gsm_fold_mac_sched.sv
// rtl/gsm_fold_mac_sched.sv - folded symmetric FIR scheduler and shared-multiplier MAC datapath
module gsm_fold_mac_sched #(
  parameter int TAPS      = 101,
  parameter int LANES     = 17,
  parameter int OUT_SHIFT = 17
) (
  input  logic                                 sys_clk,
  input  logic                                 reset_n,
  input  logic                                 sam_clk_en,
  input  logic signed [17:0]                   x_in,
  input  logic                                 coef_wr_en,
  input  logic [$clog2((TAPS+1)/2)-1:0]        coef_addr,
  input  logic signed [17:0]                   coef_data,
  output logic                                 busy,
  output logic signed [17:0]                   y,
  output logic                                 y_valid,
  output logic                                 overrun
);

  localparam int UNIQ   = (TAPS + 1) / 2;
  localparam int C      = (TAPS - 1) / 2;
  localparam int PHASES = (UNIQ + LANES - 1) / LANES;
  localparam int AW     = $clog2(UNIQ);
  localparam int TIW    = $clog2(TAPS);
  localparam int PW     = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int ACCW   = 44;
  localparam int PRW    = 37;

  localparam logic [ACCW-1:0]        RND     = ACCW'(64'd1 << (OUT_SHIFT - 1));
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(131071);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-131072);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                   state;
  logic [PW-1:0]            phase;
  logic signed [17:0]       d        [TAPS];
  logic signed [17:0]       coef_tab [UNIQ];
  logic signed [ACCW-1:0]   acc;

  // A coefficient write landing on a capture edge is parked here so the
  // captured sample still sees the old table; it commits at the end of RUN.
  logic                     pend_v;
  logic [AW-1:0]            pend_addr;
  logic signed [17:0]       pend_data;

  logic [PRW-1:0]           prod [LANES];
  logic signed [ACCW-1:0]   lane_sum;
  logic signed [ACCW-1:0]   acc_rnd;
  logic signed [ACCW-1:0]   acc_sh;
  logic signed [17:0]       y_sat;

  logic capture;
  logic addr_ok;

  assign capture = sam_clk_en && (state != S_RUN);
  assign addr_ok = ({1'b0, coef_addr} < (AW+1)'(UNIQ));

  // One shared multiplier per lane; lane k handles unique coefficient phase*LANES+k.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [15:0]        i_full;
    logic [TIW-1:0]     i_lo;
    logic [TIW-1:0]     i_hi;
    logic [AW-1:0]      ci;
    logic signed [17:0] cf;
    logic signed [18:0] pre;
    logic [PRW-1:0]     cf_ext;
    logic [PRW-1:0]     pre_ext;

    assign i_full  = 16'(phase) * 16'(LANES) + 16'(k);
    assign i_lo    = TIW'(i_full);
    assign i_hi    = TIW'(TAPS - 1) - i_lo;
    assign ci      = (i_full < 16'(UNIQ)) ? AW'(i_full) : '0;
    assign cf      = coef_tab[ci];

    // Pre-add mirrored taps; the centre tap stands alone and lanes past UNIQ contribute nothing.
    always_comb begin
      pre = '0;
      if (i_full < 16'(C)) begin
        pre = {d[i_lo][17], d[i_lo]} + {d[i_hi][17], d[i_hi]};
      end else if (i_full == 16'(C)) begin
        pre = {d[i_lo][17], d[i_lo]};
      end
    end

    assign cf_ext  = {{(PRW-18){cf[17]}}, cf};
    assign pre_ext = {{(PRW-19){pre[18]}}, pre};
    assign prod[k] = cf_ext * pre_ext;
  end

  // Sum all lane products for the current phase, sign-extended to accumulator width.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + {{(ACCW-PRW){prod[k][PRW-1]}}, prod[k]};
    end
  end

  assign acc_rnd = acc + RND;
  assign acc_sh  = acc_rnd >>> OUT_SHIFT;

  // Clamp the rounded, scaled accumulator into the 18-bit output range.
  always_comb begin
    y_sat = acc_sh[17:0];
    if (acc_sh > SAT_MAX) begin
      y_sat = 18'sd131071;
    end else if (acc_sh < SAT_MIN) begin
      y_sat = -18'sd131072;
    end
  end

  // Sequencer: capture sample, run PHASES accumulate cycles, publish result, accept coefficient writes.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      phase     <= '0;
      acc       <= '0;
      y         <= '0;
      y_valid   <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      for (int j = 0; j < TAPS; j++) d[j] <= '0;
      for (int j = 0; j < UNIQ; j++) coef_tab[j] <= '0;
    end else begin
      y_valid <= 1'b0;

      if (coef_wr_en && (state != S_RUN) && addr_ok) begin
        if (capture) begin
          pend_v    <= 1'b1;
          pend_addr <= coef_addr;
          pend_data <= coef_data;
        end else begin
          coef_tab[coef_addr] <= coef_data;
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE) begin
            y       <= y_sat;
            y_valid <= 1'b1;
          end
          if (sam_clk_en) begin
            for (int j = TAPS - 1; j > 0; j--) d[j] <= d[j-1];
            d[0]  <= x_in;
            acc   <= '0;
            phase <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          acc <= acc + lane_sum;
          if (sam_clk_en) begin
            overrun <= 1'b1;
          end
          if (phase == PW'(PHASES - 1)) begin
            busy  <= 1'b0;
            state <= S_DONE;
            if (pend_v) begin
              coef_tab[pend_addr] <= pend_data;
              pend_v              <= 1'b0;
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gsm_fold_mac_sched.sv
// tb/tb_gsm_fold_mac_sched.sv - directed bench with direct-form FIR reference model
module tb_gsm_fold_mac_sched;

  localparam int TAPS   = 101;
  localparam int UNIQ   = 51;
  localparam int PHASES = 3;

  logic               sys_clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               sam_clk_en = 1'b0;
  logic signed [17:0] x_in = '0;
  logic               coef_wr_en = 1'b0;
  logic [5:0]         coef_addr = '0;
  logic signed [17:0] coef_data = '0;
  logic               busy;
  logic signed [17:0] y;
  logic               y_valid;
  logic               overrun;

  gsm_fold_mac_sched #(.TAPS(TAPS), .LANES(17), .OUT_SHIFT(17)) dut (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .sam_clk_en (sam_clk_en),
    .x_in       (x_in),
    .coef_wr_en (coef_wr_en),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .busy       (busy),
    .y          (y),
    .y_valid    (y_valid),
    .overrun    (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: sample history, full coefficient set, timing of accepted samples.
  longint m_hist [TAPS];
  longint m_h    [UNIQ];
  int     cyc = 0;
  int     last_cap = -1000;
  int     out_cyc = -1;
  longint out_val = 0;
  longint exp_y = 0;
  logic   exp_valid = 1'b0;
  logic   exp_busy = 1'b0;
  logic   exp_ovr = 1'b0;
  longint ylog [$];

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Direct-form convolution over the full symmetric impulse response.
  function automatic longint model_y();
    longint acc = 0;
    longint r;
    for (int j = 0; j < TAPS; j++) begin
      acc += ((j < UNIQ) ? m_h[j] : m_h[TAPS-1-j]) * m_hist[j];
    end
    r = (acc + 65536) >>> 17;
    if (r > 131071) r = 131071;
    if (r < -131072) r = -131072;
    return r;
  endfunction

  always @(posedge sys_clk) begin
    bit in_run;
    cyc++;
    if (!reset_n) begin
      for (int j = 0; j < TAPS; j++) m_hist[j] = 0;
      for (int j = 0; j < UNIQ; j++) m_h[j] = 0;
      last_cap = -1000; out_cyc = -1;
      exp_y = 0; exp_valid = 0; exp_busy = 0; exp_ovr = 0;
    end else begin
      exp_valid = (cyc == out_cyc);
      if (exp_valid) exp_y = out_val;
      in_run = (cyc - last_cap >= 1) && (cyc - last_cap <= PHASES);
      if (sam_clk_en && in_run) exp_ovr = 1;
      if (sam_clk_en && !in_run) begin
        for (int j = TAPS - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = x_in;
        out_val   = model_y();
        out_cyc   = cyc + PHASES + 1;
        last_cap  = cyc;
      end
      if (coef_wr_en && !in_run && coef_addr < UNIQ) m_h[coef_addr] = coef_data;
      exp_busy = (cyc - last_cap >= 0) && (cyc - last_cap <= PHASES - 1);
    end
    #1;
    check("busy", busy, exp_busy);
    check("y_valid", y_valid, exp_valid);
    check("y", y, exp_y);
    check("overrun", overrun, exp_ovr);
    if (y_valid) ylog.push_back(y);
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic wr(input int addr, input int data);
    coef_wr_en = 1'b1; coef_addr = 6'(addr); coef_data = 18'(data);
    tick();
    coef_wr_en = 1'b0;
  endtask

  task automatic sample(input int x);
    sam_clk_en = 1'b1; x_in = 18'(x);
    tick();
    sam_clk_en = 1'b0; x_in = '0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    ylog.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_y", y, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    tick();

    // Centre tap only: output appears once the first sample reaches d[50].
    wr(50, 65536);
    ylog.delete();
    repeat (52) sample(131071);
    tick();
    check("centre_count", ylog.size(), 52);
    check("centre_y0", ylog[0], 0);
    check("centre_y49", ylog[49], 0);
    check("centre_y50", ylog[50], 65536);
    check("centre_y51", ylog[51], 65536);

    // Impulse response of coef[i]=i+1.
    do_reset();
    for (int i = 0; i < UNIQ; i++) wr(i, i + 1);
    ylog.delete();
    sample(131071);
    repeat (100) sample(0);
    tick();
    check("imp_count", ylog.size(), 101);
    check("imp_y0", ylog[0], 1);
    check("imp_y10", ylog[10], 11);
    check("imp_y50", ylog[50], 51);
    check("imp_y90", ylog[90], 11);
    check("imp_y100", ylog[100], 1);

    // Saturation at both rails.
    do_reset();
    for (int i = 0; i < UNIQ; i++) wr(i, 131071);
    ylog.delete();
    repeat (3) sample(131071);
    repeat (6) sample(-131072);
    tick();
    check("sat_y0", ylog[0], 131070);
    check("sat_y1", ylog[1], 131071);
    check("sat_y5", ylog[5], -3);
    check("sat_y8", ylog[8], -131072);

    // Second strobe two cycles after the first is dropped.
    do_reset();
    wr(0, 65536);
    ylog.delete();
    check("ovr_before", overrun, 0);
    sam_clk_en = 1'b1; x_in = 18'sd131071;
    tick();
    sam_clk_en = 1'b0;
    tick();
    sam_clk_en = 1'b1; x_in = -18'sd5000;
    tick();
    sam_clk_en = 1'b0; x_in = '0;
    repeat (3) tick();
    check("ovr_set", overrun, 1);
    check("ovr_count", ylog.size(), 1);
    check("ovr_y0", ylog[0], 65536);
    sample(1000);
    tick();
    check("ovr_y1", ylog[1], 500);
    check("ovr_sticky", overrun, 1);

    // Coefficient writes: ignored while busy, deferred on capture edge, immediate in idle.
    do_reset();
    wr(50, 65536);
    ylog.delete();
    sam_clk_en = 1'b1; x_in = 18'sd131071;
    tick();
    sam_clk_en = 1'b0;
    check("busy_run", busy, 1);
    wr(0, 65536);
    repeat (2) tick();
    sample(131071);
    coef_wr_en = 1'b1; coef_addr = 6'd0; coef_data = 18'sd65536;
    sam_clk_en = 1'b1; x_in = 18'sd131071;
    tick();
    coef_wr_en = 1'b0; sam_clk_en = 1'b0;
    repeat (3) tick();
    sample(131071);
    wr(0, 0);
    sample(131071);
    tick();
    check("cw_count", ylog.size(), 5);
    check("cw_y0", ylog[0], 0);
    check("cw_busy_ignored", ylog[1], 0);
    check("cw_same_edge_old", ylog[2], 0);
    check("cw_same_edge_next", ylog[3], 65536);
    check("cw_idle_write", ylog[4], 0);

    // Reset during RUN phase 1.
    sam_clk_en = 1'b1; x_in = 18'sd131071;
    tick();
    sam_clk_en = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_y", y, 0);
    check("mid_rst_y_valid", y_valid, 0);
    tick(); tick();
    reset_n = 1'b1;
    ylog.delete();
    repeat (4) tick();
    check("mid_rst_no_output", ylog.size(), 0);
    wr(0, 65536);
    sample(131071);
    tick();
    check("post_rst_count", ylog.size(), 1);
    check("post_rst_y", ylog[0], 65536);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
